// File: rtl/kamacore_writeback_stage.sv
// kamacore_writeback_stage
//
// Writeback stage in front of the register file write port. It takes results from
// two producers over valid/ready handshakes: the ALU and the load unit. Each producer
// has a one-entry holding register. One entry is granted per cycle and is written to
// a registered write port (rf_we / rf_a / rf_data). pending_mask tells decode which
// destination registers still have a write in flight.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   alu_valid/ready/rd/data  ALU result handshake
//   mem_valid/ready/rd/data  load result handshake
//   rf_we, rf_a, rf_data     registered register-file write port
//   pending_mask             one bit per register with a held or outgoing write
//
// Optional feature (compile-time macro):
//   KAMACORE_WB_X0_DISCARD_EN  when defined, a granted entry with rd==0 is consumed
//                              without a write, and rd==0 never shows in pending_mask.
module kamacore_writeback_stage #(
  parameter int unsigned CPU_WIDTH      = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned STARVE_LIMIT   = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alu_valid,
  output logic                           alu_ready,
  input  logic [REG_ADDR_WIDTH-1:0]      alu_rd,
  input  logic [CPU_WIDTH-1:0]           alu_data,
  input  logic                           mem_valid,
  output logic                           mem_ready,
  input  logic [REG_ADDR_WIDTH-1:0]      mem_rd,
  input  logic [CPU_WIDTH-1:0]           mem_data,
  output logic                           rf_we,
  output logic [REG_ADDR_WIDTH-1:0]      rf_a,
  output logic [CPU_WIDTH-1:0]           rf_data,
  output logic [(2**REG_ADDR_WIDTH)-1:0] pending_mask
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

`ifdef KAMACORE_WB_X0_DISCARD_EN
  localparam bit X0Discard = 1'b1;
`else
  localparam bit X0Discard = 1'b0;
`endif

  // Holding registers
  logic                      alu_hv_q, alu_hv_d, mem_hv_q, mem_hv_d;
  logic [REG_ADDR_WIDTH-1:0] alu_rd_q, mem_rd_q;
  logic [CPU_WIDTH-1:0]      alu_data_q, mem_data_q;
  // age_q = 1 means the load entry was captured before the ALU entry
  logic                      age_q, age_d;
  logic [StarveW-1:0]        starve_q, starve_d;
  logic                      rf_we_q;
  logic [REG_ADDR_WIDTH-1:0] rf_a_q;
  logic [CPU_WIDTH-1:0]      rf_data_q;

  logic                      grant_alu, grant_mem, alu_fire, mem_fire;
  logic                      alu_stays, mem_stays, issue;
  logic [REG_ADDR_WIDTH-1:0] win_rd;
  logic [CPU_WIDTH-1:0]      win_data;

  // Arbitration
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (alu_hv_q && mem_hv_q) begin
      if (alu_rd_q == mem_rd_q) begin
        // Same destination: oldest first keeps per-register write order
        grant_mem = age_q;
        grant_alu = !age_q;
      end else if (starve_q == StarveMax) begin
        grant_alu = 1'b1;
      end else begin
        grant_mem = 1'b1;
      end
    end else begin
      grant_alu = alu_hv_q;
      grant_mem = mem_hv_q;
    end
  end

  // Ready depends only on state, never on valid
  assign alu_ready = !alu_hv_q || grant_alu;
  assign mem_ready = !mem_hv_q || grant_mem;
  assign alu_fire  = alu_valid && alu_ready;
  assign mem_fire  = mem_valid && mem_ready;
  assign alu_stays = alu_hv_q && !grant_alu;
  assign mem_stays = mem_hv_q && !grant_mem;

  assign win_rd   = grant_alu ? alu_rd_q : mem_rd_q;
  assign win_data = grant_alu ? alu_data_q : mem_data_q;
  assign issue    = (grant_alu || grant_mem) && !(X0Discard && (win_rd == '0));

  always_comb begin
    alu_hv_d = alu_fire ? 1'b1 : alu_stays;
    mem_hv_d = mem_fire ? 1'b1 : mem_stays;

    age_d = age_q;
    if (alu_fire && mem_stays) begin
      age_d = 1'b1;
    end else if (mem_fire && alu_stays) begin
      age_d = 1'b0;
    end else if (alu_fire && mem_fire) begin
      age_d = 1'b0;  // simultaneous capture: ALU counts as older
    end

    starve_d = starve_q;
    if (!alu_hv_q || grant_alu) begin
      starve_d = '0;
    end else if (grant_mem && (starve_q != StarveMax)) begin
      starve_d = starve_q + StarveW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_hv_q   <= 1'b0;
      mem_hv_q   <= 1'b0;
      alu_rd_q   <= '0;
      mem_rd_q   <= '0;
      alu_data_q <= '0;
      mem_data_q <= '0;
      age_q      <= 1'b0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_a_q     <= '0;
      rf_data_q  <= '0;
    end else begin
      alu_hv_q <= alu_hv_d;
      mem_hv_q <= mem_hv_d;
      age_q    <= age_d;
      starve_q <= starve_d;
      rf_we_q  <= issue;
      if (alu_fire) begin
        alu_rd_q   <= alu_rd;
        alu_data_q <= alu_data;
      end
      if (mem_fire) begin
        mem_rd_q   <= mem_rd;
        mem_data_q <= mem_data;
      end
      if (issue) begin
        rf_a_q    <= win_rd;
        rf_data_q <= win_data;
      end
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_a    = rf_a_q;
  assign rf_data = rf_data_q;

  always_comb begin
    pending_mask = '0;
    if (alu_hv_q && !(X0Discard && (alu_rd_q == '0))) pending_mask[alu_rd_q] = 1'b1;
    if (mem_hv_q && !(X0Discard && (mem_rd_q == '0))) pending_mask[mem_rd_q] = 1'b1;
    if (rf_we_q) pending_mask[rf_a_q] = 1'b1;
  end

endmodule
